// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C burst write engine: FSM states, NACK stage
// codes, the R/W bit value and SCL phase decoding helpers.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_SHIFT = 3'd2,
    ST_ACK   = 3'd3,
    ST_LOAD  = 3'd4,
    ST_STOP  = 3'd5,
    ST_DONE  = 3'd6
  } stateT;

  localparam logic [1:0] NACK_STAGE_DEV  = 2'd0;
  localparam logic [1:0] NACK_STAGE_REG  = 2'd1;
  localparam logic [1:0] NACK_STAGE_DATA = 2'd2;

  localparam logic I2C_WRITE_BIT = 1'b0;

  // Mid-high point of the SCL period: where ACK and START/STOP edges happen.
  function automatic logic isSampleTick(input logic [15:0] phase, input int clkDiv);
    return phase == 16'(clkDiv / 4);
  endfunction

  // Mid-low point of the SCL period: where SDA is allowed to change.
  function automatic logic isDriveTick(input logic [15:0] phase, input int clkDiv);
    return phase == 16'(3 * (clkDiv / 4));
  endfunction

  // SCL is released for the first half of the period and pulled low after.
  function automatic logic isSclLowPhase(input logic [15:0] phase, input int clkDiv);
    return phase >= 16'(clkDiv / 2);
  endfunction

  // Last released phase before SCL is pulled low; a stretching slave holds us here.
  function automatic logic isStretchPoint(input logic [15:0] phase, input int clkDiv);
    return phase == 16'(clkDiv / 2 - 1);
  endfunction

endpackage

// File: rtl/i2c_scl_gen.sv
// SCL phase generator: phase counter, open-drain SCL pull-down request and the
// sample/drive strobes. The counter can be frozen at the drive point (waiting
// for data) and, when I2C_STRETCH_EN is defined, held while a slave stretches SCL.
module i2c_scl_gen
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic freeze,
  input  logic sclIn,
  output logic sclLow,
  output logic sampleTick,
  output logic driveTick
);

  localparam int PW = $clog2(CLK_DIV);

  logic [PW-1:0] phase_r;
  logic [PW-1:0] phaseNext_s;
  logic          stretch_s;

  assign sampleTick = run && isSampleTick(16'(phase_r), CLK_DIV);
  assign driveTick  = run && isDriveTick(16'(phase_r), CLK_DIV);

`ifdef I2C_STRETCH_EN
  logic [1:0] sclSync_r;

  // Bring the externally driven SCL level into the clk domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclSync_r <= 2'b11;
    end else begin
      sclSync_r <= {sclSync_r[0], sclIn};
    end
  end

  assign stretch_s = run && isStretchPoint(16'(phase_r), CLK_DIV) && !sclSync_r[1];
`else
  logic unusedSclIn;
  assign unusedSclIn = sclIn;
  assign stretch_s   = 1'b0;
`endif

  // Next phase: hold when frozen at the drive point or stretched, else wrap-count.
  always_comb begin
    phaseNext_s = phase_r;
    if ((freeze && driveTick) || stretch_s) begin
      phaseNext_s = phase_r;
    end else if (phase_r == PW'(CLK_DIV - 1)) begin
      phaseNext_s = '0;
    end else begin
      phaseNext_s = phase_r + PW'(1);
    end
  end

  // Phase counter and registered SCL pull-down; both park when not running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_r <= '0;
      sclLow  <= 1'b0;
    end else if (!run) begin
      phase_r <= '0;
      sclLow  <= 1'b0;
    end else begin
      phase_r <= phaseNext_s;
      sclLow  <= isSclLowPhase(16'(phaseNext_s), CLK_DIV);
    end
  end

endmodule

// File: rtl/i2c_burst_write.sv
// I2C master burst write: START, device address + W, ADDR_BYTES register
// address bytes, up to MAX_LEN streamed data bytes, STOP. SDA/SCL are open
// drain (pulled low or released). Optional slave clock stretching is enabled
// by defining I2C_STRETCH_EN; the port list is the same in both builds.
module i2c_burst_write
  import i2c_pkg::*;
#(
  parameter int CLK_DIV    = 24,
  parameter int ADDR_BYTES = 1,
  parameter int MAX_LEN    = 16,
  parameter int LEN_W      = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [6:0]              dev_addr,
  input  logic [8*ADDR_BYTES-1:0] reg_addr,
  input  logic [LEN_W-1:0]        len,
  input  logic [7:0]              wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    nack,
  output logic [1:0]              nack_stage,
  inout  wire                     scl,
  inout  wire                     sda
);

  stateT                   state_r;
  logic [7:0]              shift_r;
  logic [2:0]              bitCnt_r;
  logic [8*ADDR_BYTES-1:0] regShift_r;
  logic [1:0]              regLeft_r;
  logic [LEN_W-1:0]        dataLeft_r;
  logic [1:0]              stage_r;
  logic                    sdaLow_r;
  logic                    halfDone_r;
  logic [1:0]              sdaSync_r;
  logic                    sdaIn_s;
  logic                    sclLow_s;
  logic                    sampleTick_s;
  logic                    driveTick_s;
  logic                    freeze_s;

  assign scl      = sclLow_s ? 1'b0 : 1'bz;
  assign sda      = sdaLow_r ? 1'b0 : 1'bz;
  assign sdaIn_s  = sdaSync_r[1];
  assign freeze_s = (state_r == ST_LOAD) && !wr_valid;

  i2c_scl_gen #(.CLK_DIV(CLK_DIV)) u_sclGen (
    .clk       (clk),
    .rst       (rst),
    .run       (busy),
    .freeze    (freeze_s),
    .sclIn     (scl),
    .sclLow    (sclLow_s),
    .sampleTick(sampleTick_s),
    .driveTick (driveTick_s)
  );

  // Synchronise the SDA line level for ACK sampling.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sdaSync_r <= 2'b11;
    end else begin
      sdaSync_r <= {sdaSync_r[0], sda};
    end
  end

  // Transaction sequencer; all outputs and the SDA pull-down are registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      shift_r    <= 8'h00;
      bitCnt_r   <= 3'd0;
      regShift_r <= '0;
      regLeft_r  <= 2'd0;
      dataLeft_r <= '0;
      stage_r    <= NACK_STAGE_DEV;
      sdaLow_r   <= 1'b0;
      halfDone_r <= 1'b0;
      wr_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      nack       <= 1'b0;
      nack_stage <= NACK_STAGE_DEV;
    end else begin
      wr_ready <= 1'b0;
      done     <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            nack       <= 1'b0;
            nack_stage <= NACK_STAGE_DEV;
            shift_r    <= {dev_addr, I2C_WRITE_BIT};
            regShift_r <= reg_addr;
            regLeft_r  <= 2'(ADDR_BYTES);
            dataLeft_r <= (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
            stage_r    <= NACK_STAGE_DEV;
            bitCnt_r   <= 3'd0;
            halfDone_r <= 1'b0;
            state_r    <= ST_START;
          end
        end
        ST_START: begin
          // SDA falls while SCL is high: START condition.
          if (sampleTick_s) begin
            sdaLow_r <= 1'b1;
            state_r  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (driveTick_s) begin
            sdaLow_r <= ~shift_r[7];
            shift_r  <= {shift_r[6:0], 1'b0};
            if (bitCnt_r == 3'd7) begin
              bitCnt_r   <= 3'd0;
              halfDone_r <= 1'b0;
              state_r    <= ST_ACK;
            end else begin
              bitCnt_r <= bitCnt_r + 3'd1;
            end
          end
        end
        ST_ACK: begin
          if (driveTick_s && !halfDone_r) begin
            sdaLow_r   <= 1'b0;
            halfDone_r <= 1'b1;
          end else if (sampleTick_s && halfDone_r) begin
            halfDone_r <= 1'b0;
            if (sdaIn_s) begin
              nack       <= 1'b1;
              nack_stage <= stage_r;
              state_r    <= ST_STOP;
            end else if (regLeft_r != 2'd0) begin
              shift_r    <= regShift_r[8*ADDR_BYTES-1 -: 8];
              regShift_r <= regShift_r << 8;
              regLeft_r  <= regLeft_r - 2'd1;
              stage_r    <= NACK_STAGE_REG;
              state_r    <= ST_SHIFT;
            end else if (dataLeft_r != '0) begin
              dataLeft_r <= dataLeft_r - LEN_W'(1);
              stage_r    <= NACK_STAGE_DATA;
              state_r    <= ST_LOAD;
            end else begin
              state_r <= ST_STOP;
            end
          end
        end
        ST_LOAD: begin
          // The data MSB goes on the wire in the same drive slot it is accepted,
          // so the byte keeps the normal bit spacing.
          if (driveTick_s && wr_valid) begin
            wr_ready <= 1'b1;
            shift_r  <= {wr_data[6:0], 1'b0};
            sdaLow_r <= ~wr_data[7];
            bitCnt_r <= 3'd1;
            state_r  <= ST_SHIFT;
          end
        end
        ST_STOP: begin
          if (driveTick_s && !halfDone_r) begin
            sdaLow_r   <= 1'b1;
            halfDone_r <= 1'b1;
          end else if (sampleTick_s && halfDone_r) begin
            // SDA rises while SCL is high: STOP condition.
            sdaLow_r   <= 1'b0;
            halfDone_r <= 1'b0;
            done       <= 1'b1;
            busy       <= 1'b0;
            state_r    <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          sdaLow_r <= 1'b0;
          busy     <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
